// File: rtl/freq_divider_if.sv
// freq_divider_if: control inputs and divided-clock/tick outputs of freq_divider.
//   en, clr       : master -> divider (count enable, synchronous clear)
//   clk_*         : divider -> master (50% duty square waves, one per stage)
//   tick_*        : divider -> master (one-cycle wrap strobes, one per stage)
interface freq_divider_if;
  logic en;
  logic clr;
  logic clk_1000KHz;
  logic clk_10KHz;
  logic clk_100Hz;
  logic clk_1Hz;
  logic tick_1MHz;
  logic tick_10KHz;
  logic tick_100Hz;
  logic tick_1Hz;
  modport master (
    output en, clr,
    input  clk_1000KHz, clk_10KHz, clk_100Hz, clk_1Hz,
    input  tick_1MHz, tick_10KHz, tick_100Hz, tick_1Hz
  );
  modport slave (
    input  en, clr,
    output clk_1000KHz, clk_10KHz, clk_100Hz, clk_1Hz,
    output tick_1MHz, tick_10KHz, tick_100Hz, tick_1Hz
  );
endinterface

// File: rtl/freq_divider.sv
// freq_divider: four cascaded modulo-DIV counters producing square waves and wrap ticks.
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : slave side of freq_divider_if (en, clr in; clk_* and tick_* out)
module freq_divider #(
  parameter int DIV = 100,
  localparam int CW = $clog2(DIV)
) (
  input logic clk,
  input logic rst_n,
  freq_divider_if.slave bus
);
  localparam logic [CW-1:0] MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  logic [3:0][CW-1:0] c_q, c_d;
  logic [3:0] carry, adv, sq_q, sq_d, tk_q, tk_d;
  // Squares are computed from next-state counts so the registered output
  // tracks (ck >= DIV/2) in the same cycle as the count itself.
  always_comb begin
    carry[0] = bus.en & (c_q[0] == MAX);
    for (int k = 1; k < 4; k++) carry[k] = carry[k-1] & (c_q[k] == MAX);
    adv = {carry[2:0], bus.en};
    for (int k = 0; k < 4; k++) begin
      c_d[k]  = bus.clr ? '0 : !adv[k] ? c_q[k] : (c_q[k] == MAX) ? '0 : c_q[k] + 1'b1;
      sq_d[k] = c_d[k] >= HALF;
    end
    tk_d = bus.clr ? '0 : carry;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q  <= '0;
      sq_q <= '0;
      tk_q <= '0;
    end else begin
      c_q  <= c_d;
      sq_q <= sq_d;
      tk_q <= tk_d;
    end
  end
  assign bus.clk_1000KHz = sq_q[0];
  assign bus.clk_10KHz   = sq_q[1];
  assign bus.clk_100Hz   = sq_q[2];
  assign bus.clk_1Hz     = sq_q[3];
  assign bus.tick_1MHz   = tk_q[0];
  assign bus.tick_10KHz  = tk_q[1];
  assign bus.tick_100Hz  = tk_q[2];
  assign bus.tick_1Hz    = tk_q[3];
endmodule
